// File: rtl/operand_mux_arbiter.sv
// Round-robin arbiter sharing one N-bit ALU operand path between requesters A and B.
// Drives the 2:1 operand mux select and presents the granted operand with valid/ready.
module operand_mux_arbiter #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_a,
    input  logic [N-1:0] data_a,
    output logic         ack_a,
    input  logic         req_b,
    input  logic [N-1:0] data_b,
    output logic         ack_b,
    output logic         sel,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StGntA, StGntB} state_e;

    state_e         state_q, state_d;
    logic           last_q, last_d;   // 0 = A was last granted, 1 = B
    logic           sel_q, sel_d;
    logic           valid_q, valid_d;
    logic [N-1:0]   data_q, data_d;

    logic handshake;
    logic arbitrate;
    logic cand_a, cand_b;
    logic pick_a, pick_b;

    always_comb begin
        handshake = valid_q & out_ready;
        arbitrate = (state_q == StIdle) | handshake;
        // The requester being acked still holds req this cycle; mask it out.
        cand_a    = req_a & ~(handshake & (state_q == StGntA));
        cand_b    = req_b & ~(handshake & (state_q == StGntB));
        pick_b    = cand_b & (~cand_a | ~last_q);
        pick_a    = cand_a & ~pick_b;

        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        data_d  = data_q;

        if (arbitrate) begin
            if (pick_a) begin
                state_d = StGntA;
                last_d  = 1'b0;
                sel_d   = 1'b0;
                valid_d = 1'b1;
                data_d  = data_a;
            end else if (pick_b) begin
                state_d = StGntB;
                last_d  = 1'b1;
                sel_d   = 1'b1;
                valid_d = 1'b1;
                data_d  = data_b;
            end else begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        ack_a     = handshake & (state_q == StGntA) & ~rst;
        ack_b     = handshake & (state_q == StGntB) & ~rst;
        sel       = sel_q;
        out_valid = valid_q;
        out_data  = data_q;
        busy      = (state_q != StIdle);
    end

endmodule
